// File: rtl/display_pkg.sv
// Shared types and default 640x480@60 timing constants for the display sync generator.
package display_pkg;

   typedef logic [9:0] pix_cnt_t;

   localparam int unsigned HActive = 640;
   localparam int unsigned HFp     = 16;
   localparam int unsigned HSync   = 96;
   localparam int unsigned HBp     = 48;
   localparam int unsigned VActive = 480;
   localparam int unsigned VFp     = 10;
   localparam int unsigned VSync   = 2;
   localparam int unsigned VBp     = 33;

   function automatic int unsigned seg_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/display_syncgen_if.sv
// Timing bus from the sync generator to pixel-fetch / RGB output logic.
// VBLANK_STB is present only when SYNCGEN_VBLANK_STB_EN is defined.
interface display_syncgen_if;
   import display_pkg::*;

   pix_cnt_t HCNT;
   pix_cnt_t VCNT;
   logic     HSYNC;
   logic     VSYNC;
   logic     DE;
   logic     FRAME_START;
`ifdef SYNCGEN_VBLANK_STB_EN
   logic     VBLANK_STB;

   modport master (output HCNT, VCNT, HSYNC, VSYNC, DE, FRAME_START, VBLANK_STB);
   modport slave  (input  HCNT, VCNT, HSYNC, VSYNC, DE, FRAME_START, VBLANK_STB);
`else
   modport master (output HCNT, VCNT, HSYNC, VSYNC, DE, FRAME_START);
   modport slave  (input  HCNT, VCNT, HSYNC, VSYNC, DE, FRAME_START);
`endif
endinterface

// File: rtl/syncgen_axis.sv
// One timing axis: wrapping position counter plus combinational sync/active decode of it.
module syncgen_axis
   import display_pkg::*;
#(
   parameter int unsigned Active = HActive,
   parameter int unsigned Fp     = HFp,
   parameter int unsigned Sync   = HSync,
   parameter int unsigned Bp     = HBp
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     en_i,
   output pix_cnt_t cnt_o,
   output logic     wrap_o,
   output logic     sync_o,
   output logic     active_o
);

   localparam int unsigned Total     = seg_total(Active, Fp, Sync, Bp);
   localparam pix_cnt_t    Last      = pix_cnt_t'(Total - 1);
   localparam pix_cnt_t    ActEnd    = pix_cnt_t'(Active);
   localparam pix_cnt_t    SyncStart = pix_cnt_t'(Active + Fp);
   localparam pix_cnt_t    SyncEnd   = pix_cnt_t'(Active + Fp + Sync);

   if (Total > 1024) begin : g_total_chk
      $error("syncgen_axis: segment total exceeds 10-bit counter range");
   end

   pix_cnt_t cnt_q, cnt_d;

   assign wrap_o   = en_i && (cnt_q == Last);
   assign sync_o   = (cnt_q >= SyncStart) && (cnt_q < SyncEnd);
   assign active_o = cnt_q < ActEnd;
   assign cnt_o    = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + 10'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/display_syncgen.sv
// VGA timing generator: registered counters, syncs, DE and frame strobe in the pixel clock domain.
// Optional VBLANK_STB output enabled by defining SYNCGEN_VBLANK_STB_EN.
module display_syncgen
   import display_pkg::*;
#(
   parameter int unsigned H_ACTIVE = HActive,
   parameter int unsigned H_FP     = HFp,
   parameter int unsigned H_SYNC   = HSync,
   parameter int unsigned H_BP     = HBp,
   parameter int unsigned V_ACTIVE = VActive,
   parameter int unsigned V_FP     = VFp,
   parameter int unsigned V_SYNC   = VSync,
   parameter int unsigned V_BP     = VBp,
   parameter logic        SYNC_POL = 1'b0
) (
   input  logic                     PCK,
   input  logic                     RST,
   display_syncgen_if.master        bus
);

   pix_cnt_t h_cnt, v_cnt;
   logic     h_wrap, v_wrap, h_sync, v_sync, h_active, v_active;
   logic     unused_v_wrap;

   syncgen_axis #(
      .Active (H_ACTIVE),
      .Fp     (H_FP),
      .Sync   (H_SYNC),
      .Bp     (H_BP)
   ) u_h_axis (
      .clk_i    (PCK),
      .rst_i    (RST),
      .en_i     (1'b1),
      .cnt_o    (h_cnt),
      .wrap_o   (h_wrap),
      .sync_o   (h_sync),
      .active_o (h_active)
   );

   // The vertical axis steps (and wraps) on the same edge the horizontal axis wraps.
   syncgen_axis #(
      .Active (V_ACTIVE),
      .Fp     (V_FP),
      .Sync   (V_SYNC),
      .Bp     (V_BP)
   ) u_v_axis (
      .clk_i    (PCK),
      .rst_i    (RST),
      .en_i     (h_wrap),
      .cnt_o    (v_cnt),
      .wrap_o   (v_wrap),
      .sync_o   (v_sync),
      .active_o (v_active)
   );

   assign unused_v_wrap = v_wrap;

   pix_cnt_t hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic     hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;

   always_comb begin
      hcnt_d  = h_cnt;
      vcnt_d  = v_cnt;
      hsync_d = h_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d = v_sync ? SYNC_POL : ~SYNC_POL;
      de_d    = h_active && v_active;
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
   end

   always_ff @(posedge PCK) begin
      if (RST) begin
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         de_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         de_q    <= de_d;
         fs_q    <= fs_d;
      end
   end

   assign bus.HCNT        = hcnt_q;
   assign bus.VCNT        = vcnt_q;
   assign bus.HSYNC       = hsync_q;
   assign bus.VSYNC       = vsync_q;
   assign bus.DE          = de_q;
   assign bus.FRAME_START = fs_q;

`ifdef SYNCGEN_VBLANK_STB_EN
   logic vb_q, vb_d;

   always_comb begin
      vb_d = (h_cnt == '0) && (v_cnt == pix_cnt_t'(V_ACTIVE));
   end

   always_ff @(posedge PCK) begin
      if (RST) begin
         vb_q <= 1'b0;
      end else begin
         vb_q <= vb_d;
      end
   end

   assign bus.VBLANK_STB = vb_q;
`endif

endmodule

// File: tb/tb_display_syncgen.sv
// Bench: default-timing DUT for reset/line checks, shrunken-timing DUT for frame-level checks.
module tb_display_syncgen;
   import display_pkg::*;

   localparam int SHA = 20, SHF = 4, SHS = 6, SHB = 5, SVA = 12, SVF = 2, SVS = 3, SVB = 4;
   localparam int SHT = SHA + SHF + SHS + SHB;  // 35
   localparam int SVT = SVA + SVF + SVS + SVB;  // 21
   localparam int SFRAME = SHT * SVT;           // 735

   typedef struct packed {
      logic [9:0] hcnt;
      logic [9:0] vcnt;
      logic       hsync;
      logic       vsync;
      logic       de;
      logic       fs;
      logic       vb;
   } obs_t;

   logic PCK = 1'b0;
   logic RST = 1'b1;
   always #5 PCK = ~PCK;

   display_syncgen_if if_full ();
   display_syncgen_if if_small ();

   display_syncgen dut_full (.PCK(PCK), .RST(RST), .bus(if_full));

   display_syncgen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b1)
   ) dut_small (.PCK(PCK), .RST(RST), .bus(if_small));

   obs_t q_full[$];
   obs_t q_small[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   fh = 0, fv = 0, sh = 0, sv = 0;

   function automatic obs_t model(input int h, input int v, input int ha, input int hf,
                                  input int hs, input int va, input int vf, input int vs,
                                  input logic pol, input logic rst);
      obs_t e;
      e = '0;
      if (rst) begin
         e.hsync = ~pol;
         e.vsync = ~pol;
      end else begin
         e.hcnt  = 10'(h);
         e.vcnt  = 10'(v);
         e.hsync = (h >= ha + hf && h < ha + hf + hs) ? pol : ~pol;
         e.vsync = (v >= va + vf && v < va + vf + vs) ? pol : ~pol;
         e.de    = (h < ha) && (v < va);
         e.fs    = (h == 0) && (v == 0);
`ifdef SYNCGEN_VBLANK_STB_EN
         e.vb    = (h == 0) && (v == va);
`endif
      end
      return e;
   endfunction

   function automatic obs_t sample_full();
      obs_t o;
      o = {if_full.HCNT, if_full.VCNT, if_full.HSYNC, if_full.VSYNC, if_full.DE,
           if_full.FRAME_START, 1'b0};
`ifdef SYNCGEN_VBLANK_STB_EN
      o.vb = if_full.VBLANK_STB;
`endif
      return o;
   endfunction

   function automatic obs_t sample_small();
      obs_t o;
      o = {if_small.HCNT, if_small.VCNT, if_small.HSYNC, if_small.VSYNC, if_small.DE,
           if_small.FRAME_START, 1'b0};
`ifdef SYNCGEN_VBLANK_STB_EN
      o.vb = if_small.VBLANK_STB;
`endif
      return o;
   endfunction

   task automatic advance(inout int h, inout int v, input int ht, input int vt);
      h++;
      if (h == ht) begin
         h = 0;
         v++;
         if (v == vt) v = 0;
      end
   endtask

   // One PCK cycle: expectations are queued as RST is driven, then popped against the DUTs.
   task automatic tick(input logic rst);
      obs_t ef, es, of, os;
      RST = rst;
      q_full.push_back(model(fh, fv, 640, 16, 96, 480, 10, 2, 1'b0, rst));
      q_small.push_back(model(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS, 1'b1, rst));
      if (rst) begin
         fh = 0; fv = 0; sh = 0; sv = 0;
      end else begin
         advance(fh, fv, 800, 525);
         advance(sh, sv, SHT, SVT);
      end
      @(posedge PCK);
      #1;
      ef = q_full.pop_front();
      of = sample_full();
      vectors++;
      if (of !== ef) begin
         miscompares++;
         $display("FAIL scoreboard_full: got %h expected %h", of, ef);
      end
      es = q_small.pop_front();
      os = sample_small();
      vectors++;
      if (os !== es) begin
         miscompares++;
         $display("FAIL scoreboard_small: got %h expected %h", os, es);
      end
   endtask

   task automatic test_reset();
      repeat (5) tick(1'b1);
      vectors++;
      if ({if_full.HCNT, if_full.VCNT, if_full.DE, if_full.HSYNC, if_full.VSYNC,
           if_full.FRAME_START} !== {10'd0, 10'd0, 4'b0110}) begin
         miscompares++;
         $display("FAIL reset_full: got %0d/%0d de=%b hs=%b vs=%b fs=%b required 0/0 0 1 1 0",
                  if_full.HCNT, if_full.VCNT, if_full.DE, if_full.HSYNC, if_full.VSYNC,
                  if_full.FRAME_START);
      end
      vectors++;
      if ({if_small.HSYNC, if_small.VSYNC} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_small_syncs: got %b%b required 00", if_small.HSYNC, if_small.VSYNC);
      end
      tick(1'b0);
      vectors++;
      if ({if_full.HCNT, if_full.VCNT, if_full.DE, if_full.FRAME_START} !== {20'd0, 2'b11}) begin
         miscompares++;
         $display("FAIL reset_release: got %0d/%0d de=%b fs=%b required 0/0 de=1 fs=1",
                  if_full.HCNT, if_full.VCNT, if_full.DE, if_full.FRAME_START);
      end
   endtask

   task automatic test_line_timing();
      int n = 0;
      while (if_full.HCNT !== 10'd0 && n < 1000) begin
         tick(1'b0);
         n++;
      end
      vectors++;
      if (n >= 1000) begin
         miscompares++;
         $display("FAIL line_sync_wait: HCNT=0 not seen within 1000 cycles");
      end
      for (int line = 0; line < 2; line++) begin
         int hs_lo = 0, de_n = 0, first = -1, last = -1;
         for (int i = 0; i < 800; i++) begin
            if (!if_full.HSYNC) begin
               hs_lo++;
               if (first < 0) first = int'(if_full.HCNT);
               last = int'(if_full.HCNT);
            end
            if (if_full.DE) de_n++;
            tick(1'b0);
         end
         vectors++;
         if (if_full.HCNT !== 10'd0 || hs_lo != 96 || first != 656 || last != 751
             || de_n != 640) begin
            miscompares++;
            $display("FAIL line_timing: end HCNT=%0d hs_lo=%0d span %0d..%0d de=%0d required 0 96 656..751 640",
                     if_full.HCNT, hs_lo, first, last, de_n);
         end
      end
   endtask

   task automatic test_frame_timing();
      int n = 0;
      while (if_small.FRAME_START !== 1'b1 && n < 1000) begin
         tick(1'b0);
         n++;
      end
      for (int f = 0; f < 2; f++) begin
         int len = 0, vs_n = 0, de_n = 0;
         do begin
            if (if_small.VSYNC) vs_n++;
            if (if_small.DE) de_n++;
            tick(1'b0);
            len++;
         end while (if_small.FRAME_START !== 1'b1 && len < 1000);
         vectors++;
         if (len != SFRAME || vs_n != SVS * SHT || de_n != SHA * SVA) begin
            miscompares++;
            $display("FAIL frame_timing: period=%0d vsync=%0d de=%0d required %0d %0d %0d",
                     len, vs_n, de_n, SFRAME, SVS * SHT, SHA * SVA);
         end
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      int v_over = 0;
      while (!(if_small.HCNT == 10'(SHT - 1) && if_small.VCNT == 10'(SVT - 1)) && n < 1000) begin
         if (if_small.VCNT >= 10'(SVT)) v_over++;
         tick(1'b0);
         n++;
      end
      tick(1'b0);
      vectors++;
      if ({if_small.HCNT, if_small.VCNT, if_small.FRAME_START} !== {20'd0, 1'b1} || v_over != 0
          || n >= 1000) begin
         miscompares++;
         $display("FAIL wrap_coherence: got %0d/%0d fs=%b over=%0d required 0/0 fs=1 over=0",
                  if_small.HCNT, if_small.VCNT, if_small.FRAME_START, v_over);
      end
   endtask

   task automatic test_mid_reset();
      int n = 0;
      int len = 0;
      while (!(if_small.HCNT == 10'd27 && if_small.VCNT == 10'd15) && n < 1000) begin
         tick(1'b0);
         n++;
      end
      vectors++;
      if ({if_small.HSYNC, if_small.VSYNC} !== 2'b11) begin
         miscompares++;
         $display("FAIL mid_reset_setup: syncs %b%b required 11", if_small.HSYNC, if_small.VSYNC);
      end
      tick(1'b1);
      vectors++;
      if ({if_small.HCNT, if_small.VCNT, if_small.HSYNC, if_small.VSYNC, if_small.DE,
           if_small.FRAME_START} !== 24'd0) begin
         miscompares++;
         $display("FAIL mid_reset: got %0d/%0d hs=%b vs=%b required 0/0 syncs inactive",
                  if_small.HCNT, if_small.VCNT, if_small.HSYNC, if_small.VSYNC);
      end
      tick(1'b0);
      vectors++;
      if ({if_small.HCNT, if_small.VCNT, if_small.FRAME_START, if_small.DE} !== {20'd0, 2'b11}) begin
         miscompares++;
         $display("FAIL mid_reset_resume: got %0d/%0d fs=%b required 0/0 fs=1",
                  if_small.HCNT, if_small.VCNT, if_small.FRAME_START);
      end
      do begin
         tick(1'b0);
         len++;
      end while (if_small.FRAME_START !== 1'b1 && len < 1000);
      vectors++;
      if (len != SFRAME) begin
         miscompares++;
         $display("FAIL mid_reset_period: got %0d required %0d", len, SFRAME);
      end
   endtask

`ifdef SYNCGEN_VBLANK_STB_EN
   task automatic test_vblank();
      int len = 0, pulses = 0, at = -1;
      int hat = -1, vat = -1;
      do begin
         if (if_small.VBLANK_STB) begin
            pulses++;
            at = len;
            hat = int'(if_small.HCNT);
            vat = int'(if_small.VCNT);
         end
         tick(1'b0);
         len++;
      end while (if_small.FRAME_START !== 1'b1 && len < 1000);
      vectors++;
      if (pulses != 1 || at != SVA * SHT || hat != 0 || vat != SVA) begin
         miscompares++;
         $display("FAIL vblank_stb: pulses=%0d offset=%0d pos=%0d/%0d required 1 %0d 0/%0d",
                  pulses, at, hat, vat, SVA * SHT, SVA);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_wrap();
`ifdef SYNCGEN_VBLANK_STB_EN
      test_vblank();
`endif
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/display_syncgen.md
# display_syncgen

VGA timing generator for the 640x480@60 Hz display path. Runs entirely in the pixel clock domain (PCK, ~25.175 MHz from the MMCM pixel-clock stage). Produces registered horizontal/vertical pixel counters, HSYNC/VSYNC, display-enable and a frame-start strobe. Downstream pixel-fetch and RGB output logic consume these outputs directly.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1'b0, active level of HSYNC/VSYNC (0 = active-low)

Ports:
- PCK  input  1  pixel clock; the only clock
- RST  input  1  reset, synchronous, active-high
- HCNT  output  10  horizontal position, 0..H_TOTAL-1
- VCNT  output  10  vertical position, 0..V_TOTAL-1
- HSYNC  output  1  horizontal sync, polarity per SYNC_POL
- VSYNC  output  1  vertical sync, polarity per SYNC_POL
- DE  output  1  high while HCNT<H_ACTIVE and VCNT<V_ACTIVE
- FRAME_START  output  1  one-cycle pulse at HCNT=0, VCNT=0
- VBLANK_STB  output  1  present only with SYNCGEN_VBLANK_STB_EN (see Configuration)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters hc, vc: hc increments every PCK cycle; hc wraps H_TOTAL-1 -> 0; vc increments on that wrap; vc wraps V_TOTAL-1 -> 0 on the same cycle hc wraps.
- Decode from hc/vc, registered into outputs:
  - HSYNC active iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751).
  - VSYNC active iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC (490..491), for the whole line, HCNT 0..799.
  - DE per Interface.
  - FRAME_START per Interface.
- HCNT/VCNT outputs are registered copies of hc/vc. All outputs are mutually coherent: every output in a given cycle describes the same (HCNT, VCNT) position.
- All compares use 10-bit unsigned arithmetic. Parameters are constrained so H_TOTAL and V_TOTAL are <= 1024 (elaboration-time assertion).

## Timing
- Output latency: one PCK cycle from internal counter to outputs.
- Reset (RST=1 at a PCK edge):
  - hc, vc <= 0.
  - HCNT=0, VCNT=0, DE=0, FRAME_START=0, VBLANK_STB=0.
  - HSYNC=VSYNC=~SYNC_POL (inactive).
- First edge with RST=0: outputs show position (0,0): DE=1, FRAME_START=1.
- Reset asserted mid-frame: takes effect at the next edge regardless of position. No partial sync pulse persists past that edge.
- Steady state:
  - Line period is exactly 800 cycles.
  - Frame period is exactly 420000 cycles.
  - FRAME_START period is exactly 420000 cycles.
- Horizontal and vertical wrap on the same edge: HCNT=0, VCNT=0 and FRAME_START=1 appear together. No intermediate (0, 525) value is ever output.

## Configuration
- Macro: SYNCGEN_VBLANK_STB_EN.
- Defined:
  - Port VBLANK_STB exists.
  - One-cycle pulse at HCNT=0, VCNT=V_ACTIVE (480), i.e. the first blanking line.
  - Used to trigger frame-buffer swaps.
- Undefined:
  - Port and its logic are absent.
  - All other behaviour is identical.

## Structure
- Package display_pkg:
  - Default timing constants (H_/V_ ACTIVE, FP, SYNC, BP).
  - typedef logic [9:0] pix_cnt_t.
  - Function computing the total from the four segment lengths.
- One sub-module, syncgen_axis, instantiated twice (horizontal and vertical).
  - Ports: clock, RST, enable, segment parameters.
  - Outputs: count, wrap, sync, active.
  - Horizontal instance: enable tied high.
  - Vertical instance: enabled by the horizontal wrap.

## Test plan
- Reset: hold RST 5 cycles -> HCNT=0, VCNT=0, DE=0, HSYNC=VSYNC=1, FRAME_START=0. First cycle after release -> FRAME_START=1, DE=1.
- Line timing: run 2 lines -> HSYNC low exactly for HCNT 656..751 (96 cycles). DE high for HCNT 0..639. Line period is 800.
- Frame timing: run 2 frames -> FRAME_START pulses are 420000 cycles apart. VSYNC low for lines 490..491 (1600 cycles). DE high-count per frame is 307200.
- Wrap coherence: at HCNT=799, VCNT=524 -> next cycle HCNT=0, VCNT=0, FRAME_START=1. VCNT never reads 525.
- Mid-frame reset: assert RST at HCNT=700, VCNT=491 (inside HSYNC and VSYNC) -> next cycle both syncs inactive, counters 0. Normal timing resumes from (0,0).
- With SYNCGEN_VBLANK_STB_EN: VBLANK_STB asserts exactly once per frame, at HCNT=0, VCNT=480, 480×800=384000 cycles after FRAME_START. Without the macro, the bench compiles without the port.
